unit_arbiter: RTL and testbench

Shares one ALU and one memory port among `N_THREADS` multicycle `thread` instances, so several harts run on a single datapath. Each thread keeps its existing `unit_sel` / `unit_in` / `unit_out` / `unit_ready` contract unchanged. The arbiter grants each shared unit to one requester at a time, steers operands and results, and generates per-thread `unit_ready`. It sits between the thread array and the `alu` / memory-bus blocks in the core top level.

---
 rtl/unit_arbiter_pkg.sv | 27 ++
 rtl/unit_arbiter_picker.sv | 52 +++++
 rtl/unit_arbiter.sv | 136 +++++++++++++
 tb/tb_unit_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unit_arbiter_pkg.sv
// rtl/unit_arbiter_pkg.sv - shared types for the thread/unit arbiter
package unit_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        UNIT_SEL_NONE = 2'd0,
        UNIT_SEL_ALU  = 2'd1,
        UNIT_SEL_MEM  = 2'd2
    } unit_sel_t;

    typedef struct packed {
        word_t ctrl;
        word_t a;
        word_t b;
    } unit_in_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unit_arbiter_picker.sv
// rtl/unit_arbiter_picker.sv - rr_picker: request vector to one-hot grant (UNIT_ARBITER_ROUND_ROBIN_EN)
module rr_picker
    import unit_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

`ifdef UNIT_ARBITER_ROUND_ROBIN_EN
    logic [IW-1:0] j;

    // Scan from ptr upwards with wrap; the first requester found wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = ptr;
        for (int k = 0; k < N; k++) begin
            if (!any && req[j]) begin
                any = 1'b1;
                idx = j;
            end
            j = (j == IW'(N - 1)) ? '0 : j + 1'b1;
        end
        if (any) grant[idx] = 1'b1;
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Descending scan so the lowest index is the last to overwrite.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                any = 1'b1;
                idx = IW'(k);
            end
        end
        if (any) grant[idx] = 1'b1;
    end
`endif

endmodule

// File: rtl/unit_arbiter.sv
// rtl/unit_arbiter.sv - shares one ALU and one memory port among threads (UNIT_ARBITER_ROUND_ROBIN_EN)
module unit_arbiter
    import unit_arbiter_pkg::*;
#(
    parameter int N_THREADS = 2,
    localparam int IW = idx_width(N_THREADS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  unit_sel_t            t_sel [N_THREADS],
    input  unit_in_t             t_in  [N_THREADS],
    output word_t                t_out [N_THREADS],
    output logic [N_THREADS-1:0] t_ready,
    output unit_in_t             alu_in,
    input  word_t                alu_out,
    output logic                 mem_valid,
    output unit_in_t             mem_in,
    input  word_t                mem_out,
    input  logic                 mem_ready
);

    logic [N_THREADS-1:0] alu_rq, mem_rq, alu_grant, mem_grant;
    logic [IW-1:0]        alu_idx, mem_idx, alu_pick_ptr, mem_pick_ptr;
    logic                 alu_any, mem_any;

    mem_arb_state_t state, state_next;
    logic [IW-1:0]  owner;
    unit_in_t       req;

    always_comb begin
        for (int i = 0; i < N_THREADS; i++) begin
            alu_rq[i] = (t_sel[i] == UNIT_SEL_ALU);
            mem_rq[i] = (t_sel[i] == UNIT_SEL_MEM);
        end
    end

`ifdef UNIT_ARBITER_ROUND_ROBIN_EN
    logic [IW-1:0] alu_ptr, mem_ptr;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(N_THREADS - 1)) ? '0 : i + 1'b1;
    endfunction

    // MEM pointer moves only on completion, from whichever thread completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_ptr <= '0;
            mem_ptr <= '0;
        end else begin
            if (alu_any) alu_ptr <= next_idx(alu_idx);
            if (mem_valid && mem_ready)
                mem_ptr <= next_idx((state == MEM_IDLE) ? mem_idx : owner);
        end
    end

    assign alu_pick_ptr = alu_ptr;
    assign mem_pick_ptr = mem_ptr;
`else
    assign alu_pick_ptr = '0;
    assign mem_pick_ptr = '0;
`endif

    rr_picker #(.N(N_THREADS)) u_alu_pick (
        .req   (alu_rq),
        .ptr   (alu_pick_ptr),
        .grant (alu_grant),
        .idx   (alu_idx),
        .any   (alu_any)
    );

    rr_picker #(.N(N_THREADS)) u_mem_pick (
        .req   (mem_rq),
        .ptr   (mem_pick_ptr),
        .grant (mem_grant),
        .idx   (mem_idx),
        .any   (mem_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MEM_IDLE;
            owner <= '0;
            req   <= '0;
        end else begin
            state <= state_next;
            if (state == MEM_IDLE && mem_any) begin
                owner <= mem_idx;
                req   <= t_in[mem_idx];
            end
        end
    end

    // Memory completion is applied after the ALU/NONE steering so its data wins.
    always_comb begin
        state_next = state;
        t_ready    = '0;
        alu_in     = '0;
        mem_in     = '0;
        mem_valid  = 1'b0;
        for (int i = 0; i < N_THREADS; i++) t_out[i] = '0;
        if (!rst) begin
            for (int i = 0; i < N_THREADS; i++)
                if (t_sel[i] == UNIT_SEL_NONE) t_ready[i] = 1'b1;
            if (alu_any) begin
                alu_in           = t_in[alu_idx];
                t_ready[alu_idx] = 1'b1;
                t_out[alu_idx]   = alu_out;
            end
            case (state)
                MEM_IDLE: begin
                    if (mem_any) begin
                        mem_valid = 1'b1;
                        mem_in    = t_in[mem_idx];
                        if (mem_ready) begin
                            t_ready[mem_idx] = 1'b1;
                            t_out[mem_idx]   = mem_out;
                        end else begin
                            state_next = MEM_BUSY;
                        end
                    end
                end
                MEM_BUSY: begin
                    mem_valid = 1'b1;
                    mem_in    = req;
                    if (mem_ready) begin
                        t_ready[owner] = 1'b1;
                        t_out[owner]   = mem_out;
                        state_next     = MEM_IDLE;
                    end
                end
                default: state_next = MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unit_arbiter.sv
// tb/tb_unit_arbiter.sv - self-checking bench for unit_arbiter with a behavioural model
module tb_unit_arbiter;
    import unit_arbiter_pkg::*;

    localparam int NT = 2;
`ifdef UNIT_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    unit_sel_t     t_sel [NT];
    unit_in_t      t_in  [NT];
    word_t         t_out [NT];
    logic [NT-1:0] t_ready;
    unit_in_t      alu_in, mem_in;
    word_t         alu_out, mem_out;
    logic          mem_valid, mem_ready;

    int total = 0;
    int bad   = 0;

    int       m_alu_ptr, m_mem_ptr, m_owner;
    bit       m_busy;
    unit_in_t m_req;

    logic [NT-1:0] e_ready;
    word_t         e_out [NT];
    unit_in_t      e_alu_in, e_mem_in;
    logic          e_mem_valid;

    always #5 clk = ~clk;
    always_comb alu_out = alu_in.a + alu_in.b;

    unit_arbiter #(.N_THREADS(NT)) dut (
        .clk       (clk),
        .rst       (rst),
        .t_sel     (t_sel),
        .t_in      (t_in),
        .t_out     (t_out),
        .t_ready   (t_ready),
        .alu_in    (alu_in),
        .alu_out   (alu_out),
        .mem_valid (mem_valid),
        .mem_in    (mem_in),
        .mem_out   (mem_out),
        .mem_ready (mem_ready)
    );

    function automatic int pick(input logic [NT-1:0] rq, input int ptr);
        for (int k = 0; k < NT; k++) begin
            int j;
            j = RR ? (ptr + k) % NT : k;
            if (rq[j]) return j;
        end
        return -1;
    endfunction

    // Expected outputs for the current inputs, then advance the model one clock.
    task automatic model_step();
        logic [NT-1:0] arq, mrq;
        int w;
        e_ready = '0; e_alu_in = '0; e_mem_in = '0; e_mem_valid = 1'b0;
        for (int i = 0; i < NT; i++) e_out[i] = '0;
        if (rst) begin
            m_alu_ptr = 0; m_mem_ptr = 0; m_owner = 0; m_busy = 0; m_req = '0;
            return;
        end
        for (int i = 0; i < NT; i++) begin
            arq[i] = (t_sel[i] == UNIT_SEL_ALU);
            mrq[i] = (t_sel[i] == UNIT_SEL_MEM);
            if (t_sel[i] == UNIT_SEL_NONE) e_ready[i] = 1'b1;
        end
        w = pick(arq, m_alu_ptr);
        if (w >= 0) begin
            e_alu_in = t_in[w]; e_ready[w] = 1'b1; e_out[w] = t_in[w].a + t_in[w].b;
            m_alu_ptr = (w + 1) % NT;
        end
        if (m_busy) begin
            e_mem_valid = 1'b1; e_mem_in = m_req;
            if (mem_ready) begin
                e_ready[m_owner] = 1'b1; e_out[m_owner] = mem_out;
                m_mem_ptr = (m_owner + 1) % NT; m_busy = 0;
            end
        end else begin
            w = pick(mrq, m_mem_ptr);
            if (w >= 0) begin
                e_mem_valid = 1'b1; e_mem_in = t_in[w];
                if (mem_ready) begin
                    e_ready[w] = 1'b1; e_out[w] = mem_out; m_mem_ptr = (w + 1) % NT;
                end else begin
                    m_busy = 1; m_owner = w; m_req = t_in[w];
                end
            end
        end
    endtask

    task automatic rand_in(input int i);
        t_in[i].ctrl = $urandom(); t_in[i].a = $urandom(); t_in[i].b = $urandom();
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0; mem_out = '0;
        for (int i = 0; i < NT; i++) begin t_sel[i] = UNIT_SEL_NONE; rand_in(i); end
        #3; model_step();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; t_sel[0] = UNIT_SEL_ALU; t_sel[1] = UNIT_SEL_MEM;
        rand_in(0); rand_in(1); mem_ready = 1'b1; mem_out = 32'h1234;
        @(posedge clk); #4;
        model_step();
        total++;
        if (t_ready !== 2'b00 || t_out[0] !== 32'h0 || t_out[1] !== 32'h0 || mem_valid !== 1'b0
            || alu_in !== unit_in_t'(0) || mem_in !== unit_in_t'(0)) begin
            bad++;
            $display("FAIL reset_outputs ready=%b valid=%b out0=%h out1=%h required all zero",
                     t_ready, mem_valid, t_out[0], t_out[1]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_alu_alternate();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            int ew;
            t_sel[0] = UNIT_SEL_ALU; t_sel[1] = UNIT_SEL_ALU; rand_in(0); rand_in(1);
            #3; model_step();
            ew = RR ? c % 2 : 0;
            total++;
            if (t_ready !== (2'b01 << ew) || t_out[ew] !== t_in[ew].a + t_in[ew].b
                || t_out[1-ew] !== 32'h0) begin
                bad++;
                $display("FAIL alu_alternate c%0d ready=%b required %b out=%h required %h",
                         c, t_ready, 2'b01 << ew, t_out[ew], t_in[ew].a + t_in[ew].b);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        int pulses = 0;
        do_reset();
        t_sel[0] = UNIT_SEL_MEM; t_in[0] = '{ctrl: 32'h1, a: 32'h100, b: 32'h0};
        for (int c = 0; c < 5; c++) begin
            if (c == 2) t_in[0].a = 32'h999;
            if (c == 3) begin mem_ready = 1'b1; mem_out = 32'hDEADBEEF; end
            if (c == 4) begin t_sel[0] = UNIT_SEL_NONE; mem_ready = 1'b0; end
            #3; model_step();
            if (t_ready[0] && t_sel[0] == UNIT_SEL_MEM) pulses++;
            total++;
            if (c < 4 && (mem_valid !== 1'b1 || mem_in.a !== 32'h100)) begin
                bad++;
                $display("FAIL mem_wait_hold c%0d valid=%b addr=%h required 1 100", c, mem_valid, mem_in.a);
            end else if (c == 4 && mem_valid !== 1'b0) begin
                bad++;
                $display("FAIL mem_wait_release valid=%b required 0", mem_valid);
            end
            total++;
            if (c < 4 && (t_ready[0] !== (c == 3) || (c == 3 && t_out[0] !== 32'hDEADBEEF))) begin
                bad++;
                $display("FAIL mem_wait_ready c%0d ready0=%b out0=%h required %b deadbeef",
                         c, t_ready[0], t_out[0], c == 3);
            end
            @(posedge clk); #1;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL mem_wait_pulses got %0d required 1", pulses);
        end
    endtask

    task automatic test_mem_alu_overlap();
        do_reset();
        t_sel[0] = UNIT_SEL_MEM; rand_in(0);
        for (int c = 0; c < 3; c++) begin
            if (c >= 1) begin t_sel[1] = UNIT_SEL_ALU; rand_in(1); end
            if (c == 2) begin mem_ready = 1'b1; mem_out = $urandom(); end
            #3; model_step();
            total++;
            if (t_ready !== e_ready || t_out[0] !== e_out[0] || t_out[1] !== e_out[1]
                || mem_valid !== e_mem_valid || mem_in !== e_mem_in || alu_in !== e_alu_in
                || (c == 1 && t_ready !== 2'b10) || (c == 2 && t_ready !== 2'b11)) begin
                bad++;
                $display("FAIL mem_alu_overlap c%0d ready=%b required %b out1=%h required %h",
                         c, t_ready, e_ready, t_out[1], e_out[1]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_mem_both();
        do_reset();
        mem_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            int ew;
            t_sel[0] = UNIT_SEL_MEM; t_sel[1] = UNIT_SEL_MEM; rand_in(0); rand_in(1);
            mem_out = $urandom();
            #3; model_step();
            ew = RR ? c % 2 : 0;
            total++;
            if (t_ready !== (2'b01 << ew) || t_out[ew] !== mem_out || mem_in !== t_in[ew]
                || mem_valid !== 1'b1) begin
                bad++;
                $display("FAIL mem_both c%0d ready=%b required %b out=%h required %h",
                         c, t_ready, 2'b01 << ew, t_out[ew], mem_out);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_busy();
        do_reset();
        t_sel[0] = UNIT_SEL_MEM; t_in[0].a = 32'h200;
        for (int c = 0; c < 2; c++) begin
            #3; model_step();
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #3; model_step();
        total++;
        if (mem_valid !== 1'b0 || t_ready !== 2'b00) begin
            bad++;
            $display("FAIL reset_busy_abort valid=%b ready=%b required 0 00", mem_valid, t_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        t_sel[0] = UNIT_SEL_NONE; t_sel[1] = UNIT_SEL_MEM; t_in[1].a = 32'h300;
        mem_ready = 1'b1; mem_out = $urandom();
        #3; model_step();
        total++;
        if (t_ready !== 2'b11 || t_out[1] !== mem_out || mem_in.a !== 32'h300 || mem_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy_fresh ready=%b out1=%h addr=%h required 11 %h 300",
                     t_ready, t_out[1], mem_in.a, mem_out);
        end
        @(posedge clk); #1;
        t_sel[0] = UNIT_SEL_ALU; t_sel[1] = UNIT_SEL_ALU; mem_ready = 1'b0;
        #3; model_step();
        total++;
        if (t_ready !== 2'b01) begin
            bad++;
            $display("FAIL reset_busy_ptr ready=%b required 01", t_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_none();
        do_reset();
        t_sel[1] = UNIT_SEL_NONE;
        for (int c = 0; c < 24; c++) begin
            t_sel[0] = ($urandom_range(1, 0) == 0 && !m_busy) ? UNIT_SEL_ALU : UNIT_SEL_MEM;
            rand_in(0); rand_in(1);
            mem_ready = ($urandom_range(2, 0) == 0); mem_out = $urandom();
            #3; model_step();
            total++;
            if (t_ready[1] !== 1'b1 || t_ready !== e_ready || t_out[0] !== e_out[0]
                || t_out[1] !== 32'h0 || mem_in !== e_mem_in || alu_in !== e_alu_in) begin
                bad++;
                $display("FAIL none_thread c%0d ready=%b required %b out0=%h required %h",
                         c, t_ready, e_ready, t_out[0], e_out[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NT; i++) begin
                t_sel[i] = unit_sel_t'($urandom_range(2, 0));
                if (m_busy && m_owner == i && t_sel[i] == UNIT_SEL_ALU) t_sel[i] = UNIT_SEL_MEM;
                rand_in(i);
            end
            mem_ready = ($urandom_range(2, 0) == 0); mem_out = $urandom();
            #3; model_step();
            total++;
            if (t_ready !== e_ready || t_out[0] !== e_out[0] || t_out[1] !== e_out[1]
                || alu_in !== e_alu_in || mem_valid !== e_mem_valid || mem_in !== e_mem_in) begin
                bad++;
                $display("FAIL random c%0d ready=%b required %b out0=%h required %h out1=%h required %h valid=%b required %b",
                         c, t_ready, e_ready, t_out[0], e_out[0], t_out[1], e_out[1], mem_valid, e_mem_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_alu_alternate();
        test_mem_wait();
        test_mem_alu_overlap();
        test_mem_both();
        test_reset_busy();
        test_none();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
